fifo_write_arbiter: RTL

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ beat streams into one fifo write port.
// Optional burst locking (keep grant until req_last_i) under `FIFO_ARB_BURST_LOCK_EN.
module fifo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                     aclk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic                     fifo_write_o,
  input  logic                     fifo_full_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [31:0]              beat_count_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_gnt;
  logic [IW-1:0]   r_last;
  logic [31:0]     r_beat_cnt;
  logic            w_busy;
  logic            w_write;
  logic            w_idle_hit;
  logic [IW-1:0]   w_idle_idx;
  logic            w_busy_hit;
  logic [IW-1:0]   w_busy_idx;

`ifdef FIFO_ARB_BURST_LOCK_EN
  logic            r_locked;
`else
  logic            w_unused_last;
  assign w_unused_last = ^req_last_i;
`endif

  assign w_busy  = (r_state == S_BUSY);
  assign w_write = w_busy && req_valid_i[r_gnt] && !fifo_full_i;

  // Loops run from the far end down so the nearest valid requester wins.
  always_comb begin
    w_idle_hit = 1'b0;
    w_idle_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      int t;
      t = int'(r_last) + i;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      if (req_valid_i[t[IW-1:0]]) begin
        w_idle_hit = 1'b1;
        w_idle_idx = t[IW-1:0];
      end
    end
  end

  // Same search from the current grant, excluding the grant itself.
  always_comb begin
    w_busy_hit = 1'b0;
    w_busy_idx = '0;
    for (int i = NUM_REQ - 1; i >= 1; i--) begin
      int t;
      t = int'(r_gnt) + i;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      if (req_valid_i[t[IW-1:0]]) begin
        w_busy_hit = 1'b1;
        w_busy_idx = t[IW-1:0];
      end
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_last     <= IW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
`ifdef FIFO_ARB_BURST_LOCK_EN
      r_locked   <= 1'b0;
`endif
    end else begin
      if (w_write) r_beat_cnt <= r_beat_cnt + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (w_idle_hit) begin
            r_gnt   <= w_idle_idx;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_write) begin
            r_last <= r_gnt;
`ifdef FIFO_ARB_BURST_LOCK_EN
            if (!req_last_i[r_gnt]) begin
              r_locked <= 1'b1;
            end else begin
              r_locked <= 1'b0;
              if (w_busy_hit) r_gnt <= w_busy_idx;
            end
`else
            if (w_busy_hit) r_gnt <= w_busy_idx;
`endif
          end else if (!req_valid_i[r_gnt]) begin
`ifdef FIFO_ARB_BURST_LOCK_EN
            if (!r_locked) r_state <= S_IDLE;
`else
            r_state <= S_IDLE;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    grant_o     = '0;
    if (w_busy) begin
      grant_o[r_gnt]     = 1'b1;
      req_ready_o[r_gnt] = !fifo_full_i;
    end
  end

  assign fifo_write_o = w_write;
  assign fifo_wdata_o = req_data_i[int'(r_gnt)*WIDTH +: WIDTH];
  assign beat_count_o = r_beat_cnt;

endmodule
